clkdiv_monitor: RTL and testbench
=================================

CLKDIV_MONITOR -- requirements
Module: clkdiv_monitor

Interface
REQ-001 Parameter HALF, default 1: expected divided-clock half-period in clk cycles; 1 means divide-by-2.
REQ-002 Parameter CNTW, default 8: width of the period counter and the half_period output.
REQ-003 Parameter LOCK_COUNT, default 4: number of consecutive matching half-periods required to assert locked.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  monitor enable; synchronous, level-sensitive.
REQ-007 divclk  input  1  divided clock under test, generated from clk and sampled synchronously.
REQ-008 err_clr  input  1  synchronous clear of the sticky err flag.
REQ-009 rise  output  1  one-cycle pulse marking a detected 0->1 transition of divclk.
REQ-010 fall  output  1  one-cycle pulse marking a detected 1->0 transition of divclk.
REQ-011 half_period  output  CNTW  most recent measured half-period, in clk cycles.
REQ-012 locked  output  1  high while the divider is confirmed running at HALF.
REQ-013 err  output  1  sticky error flag for mismatch or stall.

Function
REQ-014 divclk shall be registered once into divclk_q; an edge is declared when divclk differs from divclk_q.
REQ-015 rise shall equal edge AND divclk; fall shall equal edge AND NOT divclk; both shall be registered and appear one cycle after the transition.
REQ-016 Counter cnt shall clear to 0 on every edge, increment by 1 on every cycle without an edge, and saturate at all-ones (no wrap).
REQ-017 On an edge, the measured value m shall be cnt+1 (saturating at all-ones); half_period shall load m in the same cycle.
REQ-018 The FSM shall have four states: IDLE, WAIT_EDGE, MEASURE and LOCKED.
REQ-019 IDLE: cnt and the match counter are held at 0; if enable=1, go to WAIT_EDGE.
REQ-020 WAIT_EDGE: the first edge goes to MEASURE without a comparison, because the first interval is partial.
REQ-021 MEASURE, edge with m==HALF: increment the match counter; when it reaches LOCK_COUNT, go to LOCKED and set locked=1 on the next cycle.
REQ-022 MEASURE, edge with m!=HALF: clear the match counter, stay in MEASURE, leave err unchanged.
REQ-023 LOCKED, edge with m!=HALF: set err, clear locked, clear the match counter, go to MEASURE.
REQ-024 LOCKED, cnt reaches HALF with no edge (stall): set err, clear locked, go to WAIT_EDGE.
REQ-025 Stall detection shall not operate in MEASURE or WAIT_EDGE; in those states cnt only saturates.
REQ-026 enable=0 in any state: go to IDLE next cycle and clear locked; err and half_period are held.
REQ-027 err_clr=1 shall clear err; if err_clr coincides with a new error event, the error wins and err stays 1.
REQ-028 If an edge and the stall condition coincide, the edge shall take priority and no stall error is raised.
REQ-029 rise and fall shall keep operating in every state, including IDLE.

Reset
REQ-030 When rst asserts, the following shall clear immediately: state=IDLE, cnt=0, match counter=0, divclk_q=0, rise=0, fall=0, half_period=0, locked=0, err=0.
REQ-031 Reset asserted mid-measurement shall abort the measurement with no partial update to half_period.
REQ-032 After rst deasserts, the block shall re-acquire lock only through WAIT_EDGE and LOCK_COUNT fresh matches.

Verification
REQ-033 Lock: HALF=1, divclk toggles every cycle, enable=1 -> half_period=1 and locked=1 exactly 6 cycles after the first transition (1 register + 1 partial edge + 4 matches), err=0.
REQ-034 Ratio mismatch: HALF=1, divclk toggles every 2 cycles -> half_period=2, locked stays 0, err stays 0, FSM stays in MEASURE.
REQ-035 Stall: locked at HALF=1, divclk held at 1 -> err=1 and locked=0 within 2 cycles; err_clr pulse -> err=0.
REQ-036 Saturation: CNTW=4, divclk held constant for 40 cycles then one edge -> half_period=15.
REQ-037 Async reset: rst pulsed for less than one clk period while locked -> all outputs 0 immediately, with no clk edge required.
REQ-038 Priority: err_clr asserted on the same cycle as a locked mismatch -> err=1.

Source files
------------

// File: rtl/clkdiv_monitor.sv
// Divided-clock monitor: detects divclk edges, measures half-periods against HALF,
// declares lock after LOCK_COUNT consecutive matches and flags mismatch/stall in a sticky err.
module clkdiv_monitor #(
    parameter int HALF       = 1,
    parameter int CNTW       = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            divclk,
    input  logic            err_clr,
    output logic            rise,
    output logic            fall,
    output logic [CNTW-1:0] half_period,
    output logic            locked,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

    localparam int            MW     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNTW-1:0] HALF_C = CNTW'(HALF);
    localparam logic [MW-1:0]   LOCK_C = MW'(LOCK_COUNT);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, meas;
    logic [MW-1:0]   mcnt_q, mcnt_d;
    logic            divclk_q, dedge;
    logic            hp_load, locked_d, err_evt;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    assign dedge = divclk ^ divclk_q;
    assign meas  = sat_inc(cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = dedge ? '0 : sat_inc(cnt_q);
        mcnt_d   = mcnt_q;
        hp_load  = 1'b0;
        locked_d = 1'b0;
        err_evt  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            mcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    mcnt_d  = '0;
                    state_d = WAIT_EDGE;
                end
                // The first interval after arming is partial, so it is never compared.
                WAIT_EDGE: begin
                    mcnt_d = '0;
                    if (dedge) begin
                        hp_load = 1'b1;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (dedge) begin
                        hp_load = 1'b1;
                        if (meas == HALF_C) begin
                            if (mcnt_q + MW'(1) == LOCK_C) begin
                                mcnt_d  = '0;
                                state_d = LOCKED;
                            end else begin
                                mcnt_d = mcnt_q + MW'(1);
                            end
                        end else begin
                            mcnt_d = '0;
                        end
                    end
                end
                // An edge outranks the stall check: a late edge is reported as a mismatch.
                LOCKED: begin
                    if (dedge) begin
                        hp_load = 1'b1;
                        if (meas != HALF_C) begin
                            err_evt = 1'b1;
                            mcnt_d  = '0;
                            state_d = MEASURE;
                        end else begin
                            locked_d = 1'b1;
                        end
                    end else if (cnt_q == HALF_C) begin
                        err_evt = 1'b1;
                        mcnt_d  = '0;
                        state_d = WAIT_EDGE;
                    end else begin
                        locked_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcnt_q      <= '0;
            divclk_q    <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            half_period <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            divclk_q <= divclk;
            rise     <= dedge & divclk;
            fall     <= dedge & ~divclk;
            locked   <= locked_d;
            if (hp_load)
                half_period <= meas;
            if (err_evt)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: two instances (CNTW=8 and CNTW=4) compared every cycle
// against an interval-length model, plus hand-computed checkpoints.
module tb_clkdiv_monitor;

    logic clk = 1'b0;
    logic rst, enable, divclk, err_clr;
    logic       rise0, fall0, locked0, err0;
    logic [7:0] hp0;
    logic       rise1, fall1, locked1, err1;
    logic [3:0] hp1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    clkdiv_monitor #(.HALF(1), .CNTW(8), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .divclk(divclk), .err_clr(err_clr),
        .rise(rise0), .fall(fall0), .half_period(hp0), .locked(locked0), .err(err0)
    );

    clkdiv_monitor #(.HALF(1), .CNTW(4), .LOCK_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .divclk(divclk), .err_clr(err_clr),
        .rise(rise1), .fall(fall1), .half_period(hp1), .locked(locked1), .err(err1)
    );

    // Model: tracks interval length since the last edge as a plain integer and
    // applies the monitor rules; the counter width only limits what is reported.
    localparam int M_HALF = 1;
    localparam int M_LOCK = 4;
    logic mq[2];
    int   mode[2];   // 0 idle, 1 armed, 2 measuring, 3 locked
    int   len[2];
    int   run[2];
    int   mhp[2];
    bit   mrise[2], mfall[2], mlock[2], merr[2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input int k, input int maxv);
        bit e, evt;
        int seen, meas;
        e    = (divclk != mq[k]);
        seen = imin(len[k], maxv);
        meas = imin(len[k] + 1, maxv);
        evt  = 1'b0;
        mrise[k] = e && divclk;
        mfall[k] = e && !divclk;
        mq[k]    = divclk;
        mlock[k] = 1'b0;
        len[k]   = e ? 0 : len[k] + 1;
        if (!enable) begin
            mode[k] = 0; len[k] = 0; run[k] = 0;
        end else if (mode[k] == 0) begin
            mode[k] = 1; len[k] = 0; run[k] = 0;
        end else if (mode[k] == 1) begin
            run[k] = 0;
            if (e) begin mhp[k] = meas; mode[k] = 2; end
        end else if (mode[k] == 2) begin
            if (e) begin
                mhp[k] = meas;
                if (meas == M_HALF) begin
                    run[k]++;
                    if (run[k] == M_LOCK) begin mode[k] = 3; run[k] = 0; end
                end else run[k] = 0;
            end
        end else begin
            if (e) begin
                mhp[k] = meas;
                if (meas != M_HALF) begin evt = 1'b1; run[k] = 0; mode[k] = 2; end
                else mlock[k] = 1'b1;
            end else if (seen == M_HALF) begin
                evt = 1'b1; run[k] = 0; mode[k] = 1;
            end else mlock[k] = 1'b1;
        end
        if (evt) merr[k] = 1'b1;
        else if (err_clr) merr[k] = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k] = 1'b0; mode[k] = 0; len[k] = 0; run[k] = 0; mhp[k] = 0;
                mrise[k] = 1'b0; mfall[k] = 1'b0; mlock[k] = 1'b0; merr[k] = 1'b0;
            end
        end else begin
            step(0, 255);
            step(1, 15);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rise0", rise0, mrise[0]);   check("fall0", fall0, mfall[0]);
        check("hp0", hp0, mhp[0]);         check("locked0", locked0, mlock[0]);
        check("err0", err0, merr[0]);
        check("rise1", rise1, mrise[1]);   check("fall1", fall1, mfall[1]);
        check("hp1", hp1, mhp[1]);         check("locked1", locked1, mlock[1]);
        check("err1", err1, merr[1]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_run(input int n);
        for (int i = 0; i < n; i++) begin
            divclk = ~divclk;
            tick(1);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; divclk = 1'b0; err_clr = 1'b0;
        #2;
        check("reset hp", hp0, 0);
        check("reset locked", locked0, 0);
        check("reset err", err0, 0);
        check("reset rise", rise0, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(3);

        // Lock: toggling every cycle, locked rises exactly 6 cycles after the first transition.
        toggle_run(5);
        check("lock not yet", locked0, 0);
        toggle_run(1);
        check("lock at 6", locked0, 1);
        check("lock hp", hp0, 1);
        check("lock err", err0, 0);
        toggle_run(3);                    // 9 toggles total: divclk now 1
        check("lock held", locked1, 1);

        // Stall with divclk held high.
        tick(2);
        check("stall err", err0, 1);
        check("stall locked", locked0, 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err cleared", err0, 0);

        // Relock, then a late edge coinciding with err_clr.
        toggle_run(8);
        check("relock", locked0, 1);
        tick(1);
        divclk = ~divclk; err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("priority err", err0, 1);
        check("mismatch locked", locked0, 0);
        check("mismatch hp", hp0, 2);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;

        // Ratio mismatch: toggling every 2 cycles never locks and never errors.
        for (int i = 0; i < 10; i++) begin
            divclk = ~divclk;
            tick(2);
        end
        check("ratio hp", hp0, 2);
        check("ratio locked", locked0, 0);
        check("ratio err", err0, 0);

        // Disabled: half_period held while edges continue to pulse rise/fall.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            divclk = ~divclk;
            tick(3);
        end
        check("disabled hp", hp0, 2);
        check("disabled locked", locked0, 0);

        // Saturation on the 4-bit instance.
        enable = 1'b1;
        tick(40);
        divclk = ~divclk;
        tick(1);
        check("saturated hp", hp1, 15);

        // Short asynchronous reset pulse while locked.
        toggle_run(10);
        check("pre-reset locked", locked0, 1);
        #2 rst = 1'b1;
        #1;
        check("async hp", hp0, 0);
        check("async locked", locked0, 0);
        check("async rise", rise0 | fall0, 0);
        check("async hp4", hp1, 0);
        check("async locked4", locked1, 0);
        #1 rst = 1'b0;
        tick(1);
        toggle_run(4);
        check("no early relock", locked0, 0);
        toggle_run(8);
        check("relock after reset", locked0, 1);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
